// File: rtl/alu_mdu_sequencer.sv
// ALU operation decoder plus an iterative RV32M multiply/divide sequencer.
// Define MDU_FAST_MUL_EN to compute multiplies in one cycle; divides always iterate.
module alu_mdu_sequencer #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      ALUOp,
  input  logic [6:0]      Funct7,
  input  logic [2:0]      Funct3,
  input  logic            is_rtype,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic [3:0]      Operation,
  output logic            is_mdu,
  output logic            busy,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] mdu_result
);

  localparam int unsigned CNT_W = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e                state_q, state_d;
  logic [2:0]            f3_q, f3_d;
  logic                  neg_q, neg_d;
  logic [XLEN-1:0]       b_q, b_d;
  logic [XLEN-1:0]       result_q, result_d;
  logic [2*XLEN-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  // ---------------------------------------------------------------------------
  // Base-ISA operation decode
  // ---------------------------------------------------------------------------
  assign is_mdu = (ALUOp == 2'b10) & is_rtype & (Funct7 == 7'b0000001);

  always_comb begin
    Operation = 4'b0000;
    case (ALUOp)
      2'b00: Operation = 4'b0010;
      2'b01: Operation = 4'b1000;
      2'b10: begin
        if (!is_mdu) begin
          case (Funct3)
            3'b111: Operation = 4'b0000;
            3'b110: Operation = 4'b0001;
            3'b000: Operation = (is_rtype && Funct7 == 7'b0100000) ? 4'b0110 : 4'b0010;
            3'b100: Operation = 4'b0011;
            3'b001: Operation = 4'b0100;
            3'b101: begin
              if (Funct7 == 7'b0000000)      Operation = 4'b0101;
              else if (Funct7 == 7'b0100000) Operation = 4'b0111;
              else                           Operation = 4'b0000;
            end
            3'b010:  Operation = 4'b1100;
            default: Operation = 4'b0000;
          endcase
        end
      end
      default: Operation = 4'b0000;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Handshake and operand conditioning
  // ---------------------------------------------------------------------------
  logic            accept;
  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf;

  assign in_ready   = (state_q == StIdle);
  assign busy       = (state_q != StIdle);
  assign out_valid  = (state_q == StDone);
  assign mdu_result = result_q;
  assign accept     = in_valid & in_ready & is_mdu;

  always_comb begin
    // Mul: a signed for MUL/MULH/MULHSU, b signed for MUL/MULH. Div: DIV/REM signed.
    a_signed = Funct3[2] ? ~Funct3[0] : (Funct3[1:0] != 2'b11);
    b_signed = Funct3[2] ? ~Funct3[0] : ~Funct3[1];
    a_neg    = a_signed & op_a[XLEN-1];
    b_neg    = b_signed & op_b[XLEN-1];
    a_mag    = a_neg ? -op_a : op_a;
    b_mag    = b_neg ? -op_b : op_b;
    div_zero = Funct3[2] & (op_b == '0);
    div_ovf  = Funct3[2] & ~Funct3[0] & (op_a == {1'b1, {(XLEN-1){1'b0}}}) & (op_b == '1);
  end

`ifdef MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] a_ext, b_ext, fast_prod;
  logic [XLEN-1:0]   fast_res;

  // Low 2*XLEN bits of the exact product are identical for any signedness mix.
  assign a_ext     = {{XLEN{a_neg}}, op_a};
  assign b_ext     = {{XLEN{b_neg}}, op_b};
  assign fast_prod = a_ext * b_ext;
  assign fast_res  = (Funct3[1:0] == 2'b00) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
`endif

  // ---------------------------------------------------------------------------
  // Iterative datapath: shift-add multiply and restoring divide share acc_q
  // ---------------------------------------------------------------------------
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     rem_sh;
  logic              rem_ge;
  logic [XLEN-1:0]   rem_sub;
  logic [2*XLEN-1:0] div_next;

  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, b_q};
  assign mul_next = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};

  // Shifted partial remainder needs one extra bit before the trial subtract.
  assign rem_sh   = acc_q[2*XLEN-1:XLEN-1];
  assign rem_ge   = (rem_sh >= {1'b0, b_q});
  assign rem_sub  = rem_sh[XLEN-1:0] - b_q;
  assign div_next = rem_ge ? {rem_sub, acc_q[XLEN-2:0], 1'b1}
                           : {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};

  logic [2*XLEN-1:0] mul_full;
  logic [XLEN-1:0]   div_val, div_fix, fix_result;

  always_comb begin
    mul_full   = neg_q ? -acc_q : acc_q;
    div_val    = f3_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
    div_fix    = neg_q ? -div_val : div_val;
    fix_result = div_fix;
    if (!f3_q[2]) begin
      fix_result = (f3_q[1:0] == 2'b00) ? mul_full[XLEN-1:0] : mul_full[2*XLEN-1:XLEN];
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    f3_d     = f3_q;
    neg_d    = neg_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          f3_d  = Funct3;
          // Remainders follow the dividend; everything else takes sign(a) ^ sign(b).
          neg_d = (Funct3[2] & Funct3[1]) ? a_neg : (a_neg ^ b_neg);
          b_d   = b_mag;
          acc_d = {{XLEN{1'b0}}, a_mag};
          cnt_d = '0;
          if (div_zero) begin
            result_d = Funct3[1] ? op_a : '1;
            state_d  = StDone;
          end else if (div_ovf) begin
            result_d = Funct3[1] ? '0 : op_a;
            state_d  = StDone;
`ifdef MDU_FAST_MUL_EN
          end else if (!Funct3[2]) begin
            result_d = fast_res;
            state_d  = StDone;
`endif
          end else begin
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        acc_d = f3_q[2] ? div_next : mul_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(XLEN - 1)) state_d = StFix;
      end
      StFix: begin
        result_d = fix_result;
        state_d  = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      f3_q     <= '0;
      neg_q    <= 1'b0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      f3_q     <= f3_d;
      neg_q    <= neg_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_alu_mdu_sequencer.sv
// Randomised self-checking bench for alu_mdu_sequencer against an arithmetic reference model.
module tb_alu_mdu_sequencer;

`ifdef MDU_FAST_MUL_EN
  localparam int MulLat = 1;
`else
  localparam int MulLat = 34;
`endif
  localparam int DivLat = 34;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [1:0]  ALUOp = 2'b00;
  logic [6:0]  Funct7 = '0;
  logic [2:0]  Funct3 = '0;
  logic        is_rtype = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [3:0]  Operation;
  logic        is_mdu;
  logic        busy;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] mdu_result;

  int n_checks = 0;
  int n_fail   = 0;

  alu_mdu_sequencer #(.XLEN(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ALUOp      (ALUOp),
    .Funct7     (Funct7),
    .Funct3     (Funct3),
    .is_rtype   (is_rtype),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op_a       (op_a),
    .op_b       (op_b),
    .Operation  (Operation),
    .is_mdu     (is_mdu),
    .busy       (busy),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .mdu_result (mdu_result)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got no finish, want finish");
    $fatal(1, "bench timeout");
  end

  // RV32M result from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_mdu(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    logic   ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'd0, a});
    ub  = longint'({32'd0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = 0;
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] b);
    if (f3[2] && b == 0) return 1;
    if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    if (!f3[2]) return MulLat;
    return DivLat;
  endfunction

  function automatic logic [3:0] ref_op(input logic [1:0] aop, input logic [6:0] f7,
                                        input logic [2:0] f3, input logic rt);
    if (aop == 2'b00) return 4'b0010;
    if (aop == 2'b01) return 4'b1000;
    if (aop == 2'b11) return 4'b0000;
    if (rt && f7 == 7'b0000001) return 4'b0000;
    if (f3 == 3'b111) return 4'b0000;
    if (f3 == 3'b110) return 4'b0001;
    if (f3 == 3'b000) return (rt && f7 == 7'b0100000) ? 4'b0110 : 4'b0010;
    if (f3 == 3'b100) return 4'b0011;
    if (f3 == 3'b001) return 4'b0100;
    if (f3 == 3'b101 && f7 == 7'b0000000) return 4'b0101;
    if (f3 == 3'b101 && f7 == 7'b0100000) return 4'b0111;
    if (f3 == 3'b010) return 4'b1100;
    return 4'b0000;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      4:       return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issues one M-op, scrambles the inputs after accept, returns result and edge latency.
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic rdy, output logic [31:0] res, output int lat);
    @(negedge clk);
    ALUOp = 2'b10; Funct7 = 7'b0000001; is_rtype = 1'b1;
    Funct3 = f3; op_a = a; op_b = b; in_valid = 1'b1; out_ready = rdy;
    @(posedge clk);
    #1;
    in_valid = 1'b0; Funct3 = 3'($urandom); op_a = $urandom; op_b = $urandom;
    lat = 0;
    res = '0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        res = mdu_result;
        break;
      end
    end
    if (rdy) @(posedge clk);
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || mdu_result !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_state: got rdy=%b busy=%b vld=%b res=%h want rdy=1 busy=0 vld=0 res=0",
               in_ready, busy, out_valid, mdu_result);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_decode();
    // {ALUOp, Funct7, Funct3, is_rtype, Operation, is_mdu}
    logic [17:0] tab [16];
    logic [17:0] e;
    logic [1:0]  aop;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic        rt;
    tab = '{{2'b10, 7'b0100000, 3'b000, 1'b1, 4'b0110, 1'b0},
            {2'b10, 7'b0100000, 3'b000, 1'b0, 4'b0010, 1'b0},
            {2'b10, 7'b0100000, 3'b101, 1'b1, 4'b0111, 1'b0},
            {2'b10, 7'b0100000, 3'b101, 1'b0, 4'b0111, 1'b0},
            {2'b01, 7'b0000000, 3'b000, 1'b0, 4'b1000, 1'b0},
            {2'b00, 7'b0000001, 3'b111, 1'b1, 4'b0010, 1'b0},
            {2'b11, 7'b0000000, 3'b000, 1'b1, 4'b0000, 1'b0},
            {2'b10, 7'b0000001, 3'b000, 1'b1, 4'b0000, 1'b1},
            {2'b10, 7'b0000001, 3'b110, 1'b0, 4'b0001, 1'b0},
            {2'b10, 7'b0000000, 3'b101, 1'b1, 4'b0101, 1'b0},
            {2'b10, 7'b0000000, 3'b010, 1'b1, 4'b1100, 1'b0},
            {2'b10, 7'b0000000, 3'b011, 1'b1, 4'b0000, 1'b0},
            {2'b10, 7'b0000000, 3'b100, 1'b0, 4'b0011, 1'b0},
            {2'b10, 7'b0000000, 3'b110, 1'b1, 4'b0001, 1'b0},
            {2'b10, 7'b0000000, 3'b001, 1'b0, 4'b0100, 1'b0},
            {2'b10, 7'b0000001, 3'b100, 1'b1, 4'b0000, 1'b1}};
    for (int i = 0; i < 16; i++) begin
      e = tab[i];
      ALUOp = e[17:16]; Funct7 = e[15:9]; Funct3 = e[8:6]; is_rtype = e[5];
      #1;
      n_checks++;
      if (Operation !== e[4:1] || is_mdu !== e[0]) begin
        n_fail++;
        $display("FAIL decode_table[%0d]: got op=%b mdu=%b want op=%b mdu=%b",
                 i, Operation, is_mdu, e[4:1], e[0]);
      end
    end
    for (int i = 0; i < 60; i++) begin
      aop = 2'($urandom);
      case ($urandom_range(0, 3))
        0:       f7 = 7'b0000000;
        1:       f7 = 7'b0100000;
        2:       f7 = 7'b0000001;
        default: f7 = 7'($urandom);
      endcase
      f3 = 3'($urandom);
      rt = 1'($urandom);
      ALUOp = aop; Funct7 = f7; Funct3 = f3; is_rtype = rt;
      #1;
      n_checks++;
      if (Operation !== ref_op(aop, f7, f3, rt) ||
          is_mdu !== (aop == 2'b10 && rt && f7 == 7'b0000001)) begin
        n_fail++;
        $display("FAIL decode_rand: aluop=%b f7=%b f3=%b rt=%b got op=%b mdu=%b want op=%b",
                 aop, f7, f3, rt, Operation, is_mdu, ref_op(aop, f7, f3, rt));
      end
    end
  endtask

  task automatic test_ignore_non_mdu();
    logic stayed_idle;
    stayed_idle = 1'b1;
    @(negedge clk);
    ALUOp = 2'b10; Funct7 = 7'b0000000; Funct3 = 3'b000; is_rtype = 1'b1; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (busy !== 1'b0 || in_ready !== 1'b1) stayed_idle = 1'b0;
    end
    ALUOp = 2'b00; Funct7 = 7'b0000001;
    repeat (3) begin
      @(negedge clk);
      if (busy !== 1'b0 || in_ready !== 1'b1) stayed_idle = 1'b0;
    end
    in_valid = 1'b0;
    n_checks++;
    if (stayed_idle !== 1'b1) begin
      n_fail++;
      $display("FAIL ignore_non_mdu: got busy while idle=%b want 1", stayed_idle);
    end
  endtask

  task automatic test_mul();
    logic [31:0] r;
    int          lat;
    do_op(3'd0, 32'd7, -32'd3, 1'b1, r, lat);
    n_checks++;
    if (r !== 32'hFFFF_FFEB || lat !== MulLat) begin
      n_fail++;
      $display("FAIL mul_7x-3: got %h lat %0d want ffffffeb lat %0d", r, lat, MulLat);
    end
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, r, lat);
    n_checks++;
    if (r !== 32'hFFFF_FFFE || lat !== MulLat) begin
      n_fail++;
      $display("FAIL mulhu_max: got %h lat %0d want fffffffe lat %0d", r, lat, MulLat);
    end
    do_op(3'd0, 32'd123, 32'd456, 1'b1, r, lat);
    n_checks++;
    if (r !== 32'd56088 || lat !== MulLat) begin
      n_fail++;
      $display("FAIL mul_123x456: got %0d lat %0d want 56088 lat %0d", r, lat, MulLat);
    end
  endtask

  task automatic test_div();
    logic [31:0] r;
    int          lat;
    logic [31:0] exp_r [4];
    logic [2:0]  f3s   [4];
    logic [31:0] as    [4];
    logic [31:0] bs    [4];
    f3s = '{3'd4, 3'd6, 3'd5, 3'd7};
    as  = '{-32'd20, -32'd20, 32'd100, 32'd100};
    bs  = '{32'd6, 32'd6, 32'd7, 32'd7};
    exp_r = '{32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'd14, 32'd2};
    for (int i = 0; i < 4; i++) begin
      do_op(f3s[i], as[i], bs[i], 1'b1, r, lat);
      n_checks++;
      if (r !== exp_r[i] || lat !== DivLat) begin
        n_fail++;
        $display("FAIL div_directed[%0d]: got %h lat %0d want %h lat %0d",
                 i, r, lat, exp_r[i], DivLat);
      end
    end
  endtask

  task automatic test_special();
    logic [31:0] r;
    int          lat;
    logic [31:0] exp_r [6];
    logic [2:0]  f3s   [6];
    logic [31:0] as    [6];
    logic [31:0] bs    [6];
    f3s = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6};
    as  = '{32'd5, 32'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h8000_0000, 32'h8000_0000};
    bs  = '{32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    exp_r = '{32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'h8000_0000, 32'd0};
    for (int i = 0; i < 6; i++) begin
      do_op(f3s[i], as[i], bs[i], 1'b1, r, lat);
      n_checks++;
      if (r !== exp_r[i] || lat !== 1) begin
        n_fail++;
        $display("FAIL special[%0d]: got %h lat %0d want %h lat 1", i, r, lat, exp_r[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r, a, b;
    logic [2:0]  f3;
    int          lat;
    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom);
      a  = pick_operand();
      b  = pick_operand();
      do_op(f3, a, b, 1'b1, r, lat);
      n_checks++;
      if (r !== ref_mdu(f3, a, b) || lat !== ref_lat(f3, a, b)) begin
        n_fail++;
        $display("FAIL random_op[%0d] f3=%0d a=%h b=%h: got %h lat %0d want %h lat %0d",
                 i, f3, a, b, r, lat, ref_mdu(f3, a, b), ref_lat(f3, a, b));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] r, exp_r;
    int          lat;
    logic        extra;
    exp_r = ref_mdu(3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
    do_op(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, r, lat);
    n_checks++;
    if (r !== exp_r || lat !== MulLat) begin
      n_fail++;
      $display("FAIL bp_first: got %h lat %0d want %h lat %0d", r, lat, exp_r, MulLat);
    end
    Funct3 = 3'd5; op_a = 32'd99; op_b = 32'd4; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1 || mdu_result !== exp_r) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got vld=%b rdy=%b busy=%b res=%h want 1 0 1 %h",
                 i, out_valid, in_ready, busy, mdu_result, exp_r);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: got vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
    end
    extra = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b0) extra = 1'b1;
    end
    n_checks++;
    if (extra !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_second_ignored: got activity=%b want 0", extra);
    end
  endtask

  task automatic test_reset_mid_calc();
    logic [31:0] r;
    int          lat;
    logic        seen;
    @(negedge clk);
    ALUOp = 2'b10; Funct7 = 7'b0000001; is_rtype = 1'b1;
    Funct3 = 3'd5; op_a = 32'd1000; op_b = 32'd3; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #2;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_busy: got busy=%b want 1", busy);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || mdu_result !== 32'd0) begin
      n_fail++;
      $display("FAIL mid_reset: got rdy=%b busy=%b vld=%b res=%h want 1 0 0 0",
               in_ready, busy, out_valid, mdu_result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_no_result: got vld_seen=%b rdy=%b want 0 1", seen, in_ready);
    end
    do_op(3'd5, 32'd1000, 32'd3, 1'b1, r, lat);
    n_checks++;
    if (r !== 32'd333 || lat !== DivLat) begin
      n_fail++;
      $display("FAIL mid_recover: got %0d lat %0d want 333 lat %0d", r, lat, DivLat);
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_ignore_non_mdu();
    test_mul();
    test_div();
    test_special();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_calc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_mdu_sequencer.md
Name: alu_mdu_sequencer

Overview:
- Parametrised successor to the combinational ALU operation decoder.
- Decodes ALUOp/Funct7/Funct3 into the 4-bit ALU Operation code for base-ISA ops.
- Adds an iterative RV32M multiply/divide sequencer with valid/ready handshakes, selected when Funct7 = 0000001.
- Sits in EX beside the ALU; the pipeline stalls on busy.

Parameters:
- XLEN, 32, operand/result width; any even value >= 8.
- CNT_W, $clog2(XLEN)+1, iteration counter width (derived; not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ALUOp  in  2  00 LW/SW/AUIPC, 01 branch, 10 R/I-type, 11 JAL/LUI.
- Funct7  in  7  instr[31:25].
- Funct3  in  3  instr[14:12].
- is_rtype  in  1  1 = R-type; qualifies SUB and M-ops.
- in_valid  in  1  M-op request valid.
- in_ready  out  1  sequencer can accept a request.
- op_a  in  XLEN  rs1 value.
- op_b  in  XLEN  rs2 value.
- Operation  out  4  ALU operation code (combinational).
- is_mdu  out  1  current decode is an M-op (combinational).
- busy  out  1  M-op in flight.
- out_valid  out  1  mdu_result valid.
- out_ready  in  1  consumer takes the result.
- mdu_result  out  XLEN  M-op result.

Behaviour:
- Operation decode is combinational with ALUOp = 10 unless noted:
  - AND 0000 (f3 111); OR 0001 (f3 110); ADD 0010 (f3 000, or ALUOp = 00); XOR 0011 (f3 100).
  - SLL 0100 (f3 001); SRL 0101 (f3 101, f7 0000000); SUB 0110 (f3 000, is_rtype, f7 0100000); SRA 0111 (f3 101, f7 0100000).
  - BEQ 1000 (ALUOp = 01); SLT 1100 (f3 010).
  - ALUOp = 11 or any unlisted combination -> 0000.
- is_mdu = (ALUOp == 10) & is_rtype & (Funct7 == 0000001). When is_mdu = 1, Operation = 0000.
- Handshake:
  - Request accepted on a rising edge with in_valid & in_ready & is_mdu.
  - in_valid with is_mdu = 0 is ignored.
  - in_ready = (state == IDLE).
  - Funct3 and the operands are latched on accept; later input changes have no effect.
- FSM:
  - IDLE -> CALC on accept; latch the sign-corrected magnitudes, clear the counter.
  - IDLE -> DONE directly, one edge after accept, for the special cases:
    - Divide-by-zero: DIV/DIVU quotient = all ones; REM/REMU = op_a.
    - Signed overflow (op_a = 0x80..0, op_b = all ones): DIV = op_a; REM = 0.
  - CALC: one bit per cycle for XLEN cycles.
    - Multiply: shift-add on a 2*XLEN product.
    - Divide: restoring, over {remainder, quotient}.
    - CALC -> FIX when counter == XLEN-1.
  - FIX (1 cycle): apply sign correction, select the result, then -> DONE.
    - MUL: low half. MULH/MULHSU/MULHU: high half with the matching signedness.
    - Quotient sign = sign(a) ^ sign(b). Remainder sign = sign(a).
  - DONE: out_valid = 1 and mdu_result held stable. DONE -> IDLE on out_ready.
- Latency: accept at edge 0 -> out_valid at edge XLEN+2; special cases at edge 1.
- Back-pressure: with out_ready = 0, DONE holds indefinitely and in_ready stays 0.
- busy = (state != IDLE).
- Reset (asynchronous, any state, including mid-CALC):
  - state = IDLE; in_ready = 1; busy = 0; out_valid = 0.
  - mdu_result = 0; counter and datapath registers = 0.
  - An aborted operation produces no result.

Optional Feature:
- MDU_FAST_MUL_EN defined:
  - MUL/MULH/MULHSU/MULHU compute with a single-cycle XLEN x XLEN multiplier.
  - IDLE -> DONE, out_valid at edge 1.
- Undefined:
  - The iterative path is used, with XLEN+2 latency.
- Divides are always iterative; the decode is identical in both builds.

Test Plan:
- Decode sweep: ALUOp = 10 with f3/f7/is_rtype = (000, 0100000, 1) -> Operation 0110, is_mdu 0.
  - (000, 0100000, 0) -> 0010; (101, 0100000, x) -> 0111; ALUOp = 01 -> 1000.
- MUL: a = 7, b = -3, f3 000, XLEN = 32 -> out_valid at edge 34; result 0xFFFFFFEB.
  - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- DIV/REM: a = -20, b = 6 -> DIV 0xFFFFFFFD (-3), REM 0xFFFFFFFE (-2).
  - DIVU 100/7 -> 14; REMU -> 2.
- Special cases (result at edge 1):
  - DIV a = 5, b = 0 -> 0xFFFFFFFF; REM -> 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
- Back-pressure and reset:
  - Hold out_ready = 0 for 10 cycles -> mdu_result stable, in_ready = 0, second in_valid ignored.
  - Assert rst_n = 0 at CALC cycle 12 -> out_valid = 0, in_ready = 1 immediately; no result is ever produced.
- MDU_FAST_MUL_EN build: MUL 123 x 456 -> 56088 with out_valid at edge 1.
  - DIVU 100/7 still has latency 34.
